// File: rtl/patch_assembler.sv
// Packs NUM_COMPS consecutive stream components into one patch behind a single output register.
// The register tags each patch with a per-frame index and a frame-last flag.
module patch_assembler #(
    parameter int unsigned DATA_WIDTH = 55,
    parameter int unsigned COMP_WIDTH = 11,
    parameter int unsigned NUM_COMPS  = 5,
    parameter int unsigned IDX_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  comp_valid,
    output logic                  comp_ready,
    input  logic [COMP_WIDTH-1:0] comp_data,
    input  logic                  comp_last,
    output logic [DATA_WIDTH-1:0] patch_out,
    output logic                  patch_valid,
    input  logic                  patch_ready,
    output logic [IDX_WIDTH-1:0]  patch_idx,
    output logic                  patch_last,
    output logic                  err_short
);

    localparam int unsigned CntW = (NUM_COMPS > 1) ? $clog2(NUM_COMPS) : 1;
    localparam int unsigned AsmW = DATA_WIDTH - COMP_WIDTH;
    localparam logic [CntW-1:0] LastSlot = CntW'(NUM_COMPS - 1);

    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [AsmW-1:0]       asm_q, asm_d;
    logic [IDX_WIDTH-1:0]  idx_q, idx_d;
    logic [DATA_WIDTH-1:0] patch_q, patch_d;
    logic                  valid_q, valid_d;
    logic [IDX_WIDTH-1:0]  pidx_q, pidx_d;
    logic                  plast_q, plast_d;
    logic                  err_q, err_d;

    logic accept;
    logic complete;
    logic short_end;

    // Only the completing slot can stall; a draining output register frees it in the same cycle.
    assign comp_ready = (cnt_q != LastSlot) || !valid_q || patch_ready;
    assign accept     = comp_valid && comp_ready;
    assign complete   = accept && (cnt_q == LastSlot);
    assign short_end  = accept && comp_last && (cnt_q != LastSlot);

    always_comb begin
        asm_d = asm_q;
        cnt_d = cnt_q;
        if (accept) begin
            if (complete || comp_last) begin
                asm_d = '0;
                cnt_d = '0;
            end else begin
                for (int unsigned i = 0; i < NUM_COMPS - 1; i++) begin
                    if (cnt_q == CntW'(i)) begin
                        asm_d[COMP_WIDTH*i +: COMP_WIDTH] = comp_data;
                    end
                end
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        idx_d = idx_q;
        if (complete) begin
            idx_d = comp_last ? '0 : idx_q + 1'b1;
        end else if (short_end) begin
            idx_d = '0;
        end
    end

    always_comb begin
        patch_d = patch_q;
        valid_d = valid_q;
        pidx_d  = pidx_q;
        plast_d = plast_q;
        err_d   = short_end;
        if (complete) begin
            patch_d = {comp_data, asm_q};
            valid_d = 1'b1;
            pidx_d  = idx_q;
            plast_d = comp_last;
        end else if (valid_q && patch_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            asm_q   <= '0;
            idx_q   <= '0;
            patch_q <= '0;
            valid_q <= 1'b0;
            pidx_q  <= '0;
            plast_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            asm_q   <= asm_d;
            idx_q   <= idx_d;
            patch_q <= patch_d;
            valid_q <= valid_d;
            pidx_q  <= pidx_d;
            plast_q <= plast_d;
            err_q   <= err_d;
        end
    end

    assign patch_out   = patch_q;
    assign patch_valid = valid_q;
    assign patch_idx   = pidx_q;
    assign patch_last  = plast_q;
    assign err_short   = err_q;

endmodule

// File: doc/patch_assembler.md
Name: patch_assembler

Overview:
- Upstream feeder for the KD-tree root internal_node.
- Accepts a stream of 11-bit patch components through a valid/ready handshake and packs every NUM_COMPS consecutive components into one 55-bit patch.
- Emits each patch with a valid/ready handshake, a running patch index and a frame-last flag.
- The output register decouples backpressure from the tree pipeline, so the tree sees whole patches only.

Parameters:
- DATA_WIDTH, 55, packed patch width; must equal COMP_WIDTH*NUM_COMPS.
- COMP_WIDTH, 11, width of one patch component.
- NUM_COMPS, 5, components per patch.
- IDX_WIDTH, 16, width of the patch index counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- comp_valid  input  1  comp_data is valid this cycle.
- comp_ready  output  1  assembler accepts a component this cycle.
- comp_data  input  COMP_WIDTH  component value, unsigned.
- comp_last  input  1  this component is the last of the frame.
- patch_out  output  DATA_WIDTH  packed patch; component i occupies bits [COMP_WIDTH*i+COMP_WIDTH-1 : COMP_WIDTH*i].
- patch_valid  output  1  patch_out, patch_idx and patch_last are valid.
- patch_ready  input  1  downstream consumes the patch this cycle.
- patch_idx  output  IDX_WIDTH  index of the patch within the frame, starting at 0.
- patch_last  output  1  patch ends the frame.
- err_short  output  1  one-cycle pulse: frame ended on a partial patch.

Behaviour:
- Reset:
  - patch_out = 0, patch_valid = 0, patch_idx = 0, patch_last = 0, err_short = 0.
  - Component counter = 0, assembly register = 0, internal index counter = 0.
  - Reset asserted mid-patch or mid-handshake discards all partial data immediately.
- Accept: a component transfers when comp_valid && comp_ready.
- Packing:
  - The accepted component is written into slot cnt of the assembly register; cnt then increments.
  - The first-arriving component lands in the LSBs (slot 0).
  - Values pass through unmodified; no arithmetic or sign extension.
- Completion:
  - When the accepted component is slot NUM_COMPS-1, the next clock edge loads the output register with all prior slots plus the new component.
  - Loading sets patch_valid = 1, patch_idx = internal index, and patch_last = comp_last.
  - cnt returns to 0.
  - Latency from the 5th component accept to patch_valid is 1 cycle.
- Output handshake:
  - patch_valid holds until patch_valid && patch_ready.
  - patch_out, patch_idx and patch_last stay stable while patch_valid && !patch_ready.
  - patch_valid drops on a consume edge unless a new patch loads on that same edge.
- comp_ready:
  - Equals 1 when cnt != NUM_COMPS-1, or !patch_valid, or patch_ready.
  - Slots 0..3 are never stalled.
  - The completing component stalls only while the output register is full and not draining.
  - Simultaneous consume and load gives full throughput: the new patch replaces the old one with no bubble.
  - comp_ready is combinational from patch_ready.
- Index counter:
  - Increments by 1 on each completed patch and wraps modulo 2^IDX_WIDTH.
  - Resets to 0 after a completed patch carrying patch_last = 1.
- Short frame:
  - comp_last accepted on slots 0..NUM_COMPS-2 discards the partial patch and sets cnt = 0 and the index counter = 0.
  - err_short pulses high for exactly one cycle.
  - No patch is emitted for the partial data.
  - An already-valid output patch is unaffected.
- Stall: comp_valid = 0 mid-patch holds cnt and the assembly register indefinitely.

Test Plan:
- Reset check: after reset, all outputs are 0 and comp_ready = 1.
- Basic pack: send components 3,2,3,3,3 (comp_last on the 5th) with patch_ready = 1 -> one cycle later patch_valid = 1, patch_out = 55'b00000000011_00000000011_00000000011_00000000010_00000000011, patch_idx = 0, patch_last = 1.
- Back-to-back: stream 15 components with comp_valid continuous, patch_ready = 1 and comp_last on the 15th -> three patches with patch_idx 0, 1, 2, no idle cycles between them, patch_last only on idx 2, then the index restarts at 0.
- Backpressure: hold patch_ready = 0 after the first patch and feed 5 more components -> comp_ready drops only on the 5th and patch_out stays stable. Raise patch_ready -> the first patch consumes, the second loads on the same edge, and comp_ready is high that cycle.
- Short frame: send 3 components with comp_last on the 3rd -> err_short high exactly one cycle, no patch_valid, and the next 5 components produce patch_idx = 0.
- Async reset mid-patch: after 2 components, pulse rst_n low between clock edges -> outputs clear immediately, and the next 5 components form a clean patch with idx 0.
